// File: rtl/riscv_mem_arbiter_pkg.sv
// riscv_mem_arbiter_pkg
//   Shared definitions for the instruction/data memory arbiter: requester IDs,
//   lock-state encoding and the default memory message widths.
//   Fallback definitions of the vc memory message size macros are provided
//   for builds that do not pull in the vc library headers.
`ifndef RISCV_MEM_ARBITER_PKG_SV
`define RISCV_MEM_ARBITER_PKG_SV

`ifndef VC_MEM_REQ_MSG_SZ
`define VC_MEM_REQ_MSG_SZ(a_, d_) (1 + (a_) + 2 + (d_))
`endif
`ifndef VC_MEM_RESP_MSG_SZ
`define VC_MEM_RESP_MSG_SZ(d_) (1 + 2 + (d_))
`endif

`define RISCV_MEM_ARB_ID_IMEM 1'b0
`define RISCV_MEM_ARB_ID_DMEM 1'b1

package riscv_mem_arbiter_pkg;

  localparam int unsigned REQ_SZ  = `VC_MEM_REQ_MSG_SZ(32, 32);
  localparam int unsigned RESP_SZ = `VC_MEM_RESP_MSG_SZ(32);

  localparam logic ID_IMEM = `RISCV_MEM_ARB_ID_IMEM;
  localparam logic ID_DMEM = `RISCV_MEM_ARB_ID_DMEM;

  typedef enum logic {
    LOCK_IDLE   = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_e;

  function automatic logic other_id(input logic id);
    return ~id;
  endfunction

endpackage

`endif

// File: rtl/riscv_mem_arbiter_idq.sv
// riscv_mem_arbiter_idq
//   In-order queue of 1-bit requester IDs for outstanding memory requests.
//   Ports:
//     clk, reset      clock, synchronous active-high reset (empties the queue)
//     enq, enq_id     push request and the ID to push (ignored when full)
//     deq             pop request (ignored when empty)
//     full, empty     occupancy flags
//     head            ID at the front of the queue
module riscv_mem_arbiter_idq #(
  parameter int unsigned p_depth = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enq,
  input  logic enq_id,
  input  logic deq,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int unsigned PTR_W = $clog2(p_depth);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [p_depth-1:0] mem;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_enq;
  logic               do_deq;

  assign full   = (count == CNT_W'(p_depth));
  assign empty  = (count == '0);
  assign head   = mem[rd_ptr];
  // A pop in the same cycle does not make room for a push while full.
  assign do_enq = enq & ~full;
  assign do_deq = deq & ~empty;

  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_id;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
//   Merges the core's instruction and data memory ports onto one memory port.
//   Round-robin arbitration with the grant locked until the handshake; the
//   IDs of accepted requests are queued so in-order responses can be steered
//   back to the requester. Response ports have no ready and are never stalled.
//   Ports:
//     clk, reset                    clock, synchronous active-high reset
//     imemreq_msg/val/rdy           instruction request (in/in/out)
//     imemresp_msg/val              instruction response (out)
//     dmemreq_msg/val/rdy           data request (in/in/out)
//     dmemresp_msg/val              data response (out)
//     memreq_msg/val/rdy            merged request to memory (out/out/in)
//     memresp_msg/val               memory response (in)
//     err_unexp_resp                sticky: response seen with no outstanding ID
//   Optional (macro RISCV_MEM_ARBITER_PERF_EN):
//     perf_igrant, perf_dgrant      saturating fired-request counts per port
//     perf_stall                    saturating count of cycles with a request
//                                   valid but nothing fired
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   LOCK_IDLE   | free arbitration; round-robin when both requesters valid
//   LOCK_LOCKED | selected request was stalled; selection held on lock_sel
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int unsigned p_req_sz   = REQ_SZ,
  parameter int unsigned p_resp_sz  = RESP_SZ,
  parameter int unsigned p_inflight = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [p_req_sz-1:0]  imemreq_msg,
  input  logic                 imemreq_val,
  output logic                 imemreq_rdy,
  output logic [p_resp_sz-1:0] imemresp_msg,
  output logic                 imemresp_val,
  input  logic [p_req_sz-1:0]  dmemreq_msg,
  input  logic                 dmemreq_val,
  output logic                 dmemreq_rdy,
  output logic [p_resp_sz-1:0] dmemresp_msg,
  output logic                 dmemresp_val,
  output logic [p_req_sz-1:0]  memreq_msg,
  output logic                 memreq_val,
  input  logic                 memreq_rdy,
  input  logic [p_resp_sz-1:0] memresp_msg,
  input  logic                 memresp_val,
`ifdef RISCV_MEM_ARBITER_PERF_EN
  output logic [31:0]          perf_igrant,
  output logic [31:0]          perf_dgrant,
  output logic [31:0]          perf_stall,
`endif
  output logic                 err_unexp_resp
);

  lock_state_e state, state_nxt;
  logic        lock_sel, lock_sel_nxt;
  logic        last_grant, last_grant_nxt;
  logic        sel;
  logic        sel_val;
  logic        accept_ok;
  logic        fire;
  logic        resp_pop;
  logic        q_full;
  logic        q_empty;
  logic        q_head;

  always_comb begin
    // Both-valid and neither-valid fall through to the round-robin choice.
    sel = other_id(last_grant);
    if (state == LOCK_LOCKED) begin
      sel = lock_sel;
    end else if (imemreq_val && !dmemreq_val) begin
      sel = ID_IMEM;
    end else if (dmemreq_val && !imemreq_val) begin
      sel = ID_DMEM;
    end
  end

  assign sel_val   = (sel == ID_IMEM) ? imemreq_val : dmemreq_val;
  assign accept_ok = memreq_rdy & ~q_full & ~reset;
  assign fire      = sel_val & accept_ok;

  always_comb begin
    state_nxt      = state;
    lock_sel_nxt   = lock_sel;
    last_grant_nxt = last_grant;
    if (fire) last_grant_nxt = sel;
    case (state)
      LOCK_IDLE: begin
        if (sel_val && !fire) begin
          state_nxt    = LOCK_LOCKED;
          lock_sel_nxt = sel;
        end
      end
      LOCK_LOCKED: begin
        // A dropped val while locked releases the lock without a push.
        if (fire || !sel_val) state_nxt = LOCK_IDLE;
      end
      default: state_nxt = LOCK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOCK_IDLE;
      lock_sel   <= ID_DMEM;
      last_grant <= ID_DMEM;
    end else begin
      state      <= state_nxt;
      lock_sel   <= lock_sel_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  assign memreq_msg  = (sel == ID_IMEM) ? imemreq_msg : dmemreq_msg;
  assign memreq_val  = sel_val & ~reset;
  assign imemreq_rdy = (sel == ID_IMEM) & accept_ok;
  assign dmemreq_rdy = (sel == ID_DMEM) & accept_ok;

  riscv_mem_arbiter_idq #(
    .p_depth (p_inflight)
  ) u_idq (
    .clk    (clk),
    .reset  (reset),
    .enq    (fire),
    .enq_id (sel),
    .deq    (resp_pop),
    .full   (q_full),
    .empty  (q_empty),
    .head   (q_head)
  );

  assign resp_pop     = memresp_val & ~q_empty & ~reset;
  assign imemresp_msg = memresp_msg;
  assign dmemresp_msg = memresp_msg;
  assign imemresp_val = resp_pop & (q_head == ID_IMEM);
  assign dmemresp_val = resp_pop & (q_head == ID_DMEM);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_unexp_resp <= 1'b0;
    end else if (memresp_val && q_empty) begin
      err_unexp_resp <= 1'b1;
    end
  end

`ifdef RISCV_MEM_ARBITER_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_igrant <= '0;
      perf_dgrant <= '0;
      perf_stall  <= '0;
    end else begin
      if (fire && sel == ID_IMEM && perf_igrant != '1) perf_igrant <= perf_igrant + 1'b1;
      if (fire && sel == ID_DMEM && perf_dgrant != '1) perf_dgrant <= perf_dgrant + 1'b1;
      if ((imemreq_val || dmemreq_val) && !fire && perf_stall != '1)
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
module tb_riscv_mem_arbiter;

  localparam int REQ  = 67;
  localparam int RESP = 35;
  localparam int INF  = 4;

  logic            clk;
  logic            reset;
  logic [REQ-1:0]  imemreq_msg, dmemreq_msg, memreq_msg;
  logic            imemreq_val, imemreq_rdy, dmemreq_val, dmemreq_rdy;
  logic [RESP-1:0] imemresp_msg, dmemresp_msg, memresp_msg;
  logic            imemresp_val, dmemresp_val;
  logic            memreq_val, memreq_rdy, memresp_val;
  logic            err_unexp_resp;
`ifdef RISCV_MEM_ARBITER_PERF_EN
  logic [31:0]     perf_igrant, perf_dgrant, perf_stall;
`endif

  riscv_mem_arbiter #(
    .p_req_sz   (REQ),
    .p_resp_sz  (RESP),
    .p_inflight (INF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imemreq_msg    (imemreq_msg),
    .imemreq_val    (imemreq_val),
    .imemreq_rdy    (imemreq_rdy),
    .imemresp_msg   (imemresp_msg),
    .imemresp_val   (imemresp_val),
    .dmemreq_msg    (dmemreq_msg),
    .dmemreq_val    (dmemreq_val),
    .dmemreq_rdy    (dmemreq_rdy),
    .dmemresp_msg   (dmemresp_msg),
    .dmemresp_val   (dmemresp_val),
    .memreq_msg     (memreq_msg),
    .memreq_val     (memreq_val),
    .memreq_rdy     (memreq_rdy),
    .memresp_msg    (memresp_msg),
    .memresp_val    (memresp_val),
`ifdef RISCV_MEM_ARBITER_PERF_EN
    .perf_igrant    (perf_igrant),
    .perf_dgrant    (perf_dgrant),
    .perf_stall     (perf_stall),
`endif
    .err_unexp_resp (err_unexp_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus for the next cycle.
  bit             c_rst, c_iv, c_dv, c_mr, c_rv;
  logic [REQ-1:0] c_im, c_dm;
  logic [RESP-1:0] c_rm;

  // Reference model: queue of outstanding requester IDs (0 = IMEM, 1 = DMEM),
  // the last granted port, the port held by a stalled request (-1 = none),
  // and the sticky error flag as it will appear after the next edge.
  bit  mq[$];
  bit  m_last;
  int  m_lock;
  bit  m_err;

  bit             sel_def;
  bit             exp_irdy, exp_drdy, exp_mval, exp_ival, exp_dval, exp_err;
  logic [REQ-1:0] exp_mmsg;

  function automatic logic [REQ-1:0] rand_req();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[REQ-1:0];
  endfunction

  function automatic logic [RESP-1:0] rand_resp();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[RESP-1:0];
  endfunction

  // Applies the c_* stimulus for one cycle, leaves time at mid-cycle, fills
  // exp_* for this cycle and advances the model past the coming edge.
  task automatic drive_cycle();
    int s;
    bit sv, full, fire;
    @(posedge clk);
    #1;
    reset       = c_rst;
    imemreq_val = c_iv;  imemreq_msg = c_im;
    dmemreq_val = c_dv;  dmemreq_msg = c_dm;
    memreq_rdy  = c_mr;
    memresp_val = c_rv;  memresp_msg = c_rm;
    #4;
    exp_err = m_err;
    if (c_rst) begin
      sel_def  = 1'b1;
      exp_irdy = 0; exp_drdy = 0; exp_mval = 0; exp_ival = 0; exp_dval = 0;
      exp_mmsg = '0;
      mq.delete();
      m_last = 1'b1;
      m_lock = -1;
      m_err  = 1'b0;
      return;
    end
    if (m_lock >= 0)         s = m_lock;
    else if (c_iv && !c_dv)  s = 0;
    else if (c_dv && !c_iv)  s = 1;
    else if (c_iv && c_dv)   s = m_last ? 0 : 1;
    else                     s = -1;
    sel_def  = (s >= 0);
    sv       = (s == 0) ? c_iv : (s == 1) ? c_dv : 1'b0;
    full     = (mq.size() >= INF);
    exp_irdy = (s == 0) && c_mr && !full;
    exp_drdy = (s == 1) && c_mr && !full;
    exp_mval = sv;
    exp_mmsg = (s == 0) ? c_im : c_dm;
    fire     = sv && c_mr && !full;
    exp_ival = c_rv && mq.size() > 0 && mq[0] == 1'b0;
    exp_dval = c_rv && mq.size() > 0 && mq[0] == 1'b1;
    if (c_rv) begin
      if (mq.size() > 0) void'(mq.pop_front());
      else               m_err = 1'b1;
    end
    if (fire) begin
      mq.push_back(s == 1);
      m_last = (s == 1);
      m_lock = -1;
    end else if (sv && m_lock < 0) begin
      m_lock = s;
    end else if (!sv && m_lock >= 0) begin
      m_lock = -1;
    end
  endtask

  task automatic idle_inputs();
    c_rst = 0; c_iv = 0; c_dv = 0; c_mr = 0; c_rv = 0;
    c_im = '0; c_dm = '0; c_rm = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    c_rst = 1;
    drive_cycle();
    drive_cycle();
    c_rst = 0;
  endtask

  task automatic drain();
    idle_inputs();
    for (int k = 0; k < 8 && mq.size() > 0; k++) begin
      c_rv = 1; c_rm = rand_resp();
      drive_cycle();
      n_checks++;
      if (imemresp_val !== exp_ival || dmemresp_val !== exp_dval) begin
        n_fail++;
        $display("FAIL drain_route: got ival=%b dval=%b, expected ival=%b dval=%b",
                 imemresp_val, dmemresp_val, exp_ival, exp_dval);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    c_rst = 1; c_iv = 1; c_dv = 1; c_mr = 1; c_rv = 1;
    c_im = rand_req(); c_dm = rand_req();
    for (int k = 0; k < 3; k++) begin
      drive_cycle();
      n_checks++;
      if ({imemreq_rdy, dmemreq_rdy, memreq_val, imemresp_val, dmemresp_val} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got rdy/val vector %b, expected 00000",
                 {imemreq_rdy, dmemreq_rdy, memreq_val, imemresp_val, dmemresp_val});
      end
      if (k > 0) begin
        n_checks++;
        if (err_unexp_resp !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_err: got %b expected 0", err_unexp_resp);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_single_imem();
    logic [REQ-1:0]  m;
    logic [RESP-1:0] r;
    m = rand_req();
    m[65:34] = 32'h0000_0200;
    idle_inputs();
    c_iv = 1; c_im = m; c_mr = 1;
    drive_cycle();
    n_checks++;
    if (imemreq_rdy !== 1'b1 || dmemreq_rdy !== 1'b0 || memreq_val !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: got irdy=%b drdy=%b mval=%b, expected 1 0 1",
               imemreq_rdy, dmemreq_rdy, memreq_val);
    end
    n_checks++;
    if (memreq_msg !== m) begin
      n_fail++;
      $display("FAIL single_msg: got %h expected %h", memreq_msg, m);
    end
    r = rand_resp();
    idle_inputs();
    c_rv = 1; c_rm = r;
    drive_cycle();
    n_checks++;
    if (imemresp_val !== 1'b1 || dmemresp_val !== 1'b0 || imemresp_msg !== r) begin
      n_fail++;
      $display("FAIL single_resp: got ival=%b dval=%b msg=%h, expected 1 0 %h",
               imemresp_val, dmemresp_val, imemresp_msg, r);
    end
    idle_inputs();
  endtask

  task automatic test_alternate();
    bit pat[4];
    pat = '{1'b0, 1'b1, 1'b0, 1'b1};
    apply_reset();
    c_iv = 1; c_dv = 1; c_mr = 1;
    for (int k = 0; k < 4; k++) begin
      c_im = rand_req(); c_dm = rand_req();
      drive_cycle();
      n_checks++;
      if (imemreq_rdy !== !pat[k] || dmemreq_rdy !== pat[k]) begin
        n_fail++;
        $display("FAIL alt_grant%0d: got irdy=%b drdy=%b, expected %b %b",
                 k, imemreq_rdy, dmemreq_rdy, !pat[k], pat[k]);
      end
      n_checks++;
      if (memreq_msg !== exp_mmsg) begin
        n_fail++;
        $display("FAIL alt_msg%0d: got %h expected %h", k, memreq_msg, exp_mmsg);
      end
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      c_rv = 1; c_rm = rand_resp();
      drive_cycle();
      n_checks++;
      if (imemresp_val !== !pat[k] || dmemresp_val !== pat[k] || dmemresp_msg !== c_rm) begin
        n_fail++;
        $display("FAIL alt_resp%0d: got ival=%b dval=%b, expected %b %b",
                 k, imemresp_val, dmemresp_val, !pat[k], pat[k]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    logic [REQ-1:0] dm;
    dm = rand_req();
    idle_inputs();
    c_dv = 1; c_dm = dm; c_mr = 0;
    for (int k = 0; k < 3; k++) begin
      if (k >= 1) begin c_iv = 1; c_im = rand_req(); end
      drive_cycle();
      n_checks++;
      if (memreq_msg !== dm || memreq_val !== 1'b1 || dmemreq_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL lock_hold%0d: got msg=%h val=%b drdy=%b, expected %h 1 0",
                 k, memreq_msg, memreq_val, dmemreq_rdy, dm);
      end
    end
    c_mr = 1;
    drive_cycle();
    n_checks++;
    if (dmemreq_rdy !== 1'b1 || imemreq_rdy !== 1'b0 || memreq_msg !== dm) begin
      n_fail++;
      $display("FAIL lock_fire: got drdy=%b irdy=%b, expected 1 0", dmemreq_rdy, imemreq_rdy);
    end
    c_dv = 0;
    drive_cycle();
    n_checks++;
    if (imemreq_rdy !== 1'b1 || memreq_msg !== c_im) begin
      n_fail++;
      $display("FAIL lock_next: got irdy=%b expected 1", imemreq_rdy);
    end
    drain();
  endtask

  task automatic test_full();
    int accepted = 0;
    idle_inputs();
    c_iv = 1; c_mr = 1;
    for (int k = 0; k < 6; k++) begin
      c_im = rand_req();
      drive_cycle();
      if (imemreq_rdy === 1'b1) accepted++;
      n_checks++;
      if (imemreq_rdy !== exp_irdy) begin
        n_fail++;
        $display("FAIL full_rdy%0d: got %b expected %b", k, imemreq_rdy, exp_irdy);
      end
    end
    n_checks++;
    if (accepted != INF) begin
      n_fail++;
      $display("FAIL full_count: got %0d accepted, expected %0d", accepted, INF);
    end
    c_rv = 1; c_rm = rand_resp();
    drive_cycle();
    n_checks++;
    if (imemreq_rdy !== 1'b0 || imemresp_val !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop_same: got irdy=%b ival=%b, expected 0 1", imemreq_rdy, imemresp_val);
    end
    c_rv = 0;
    drive_cycle();
    n_checks++;
    if (imemreq_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_reopen: got irdy=%b expected 1", imemreq_rdy);
    end
    drain();
  endtask

  task automatic test_unexpected();
    idle_inputs();
    c_rv = 1; c_rm = rand_resp();
    drive_cycle();
    n_checks++;
    if (imemresp_val !== 1'b0 || dmemresp_val !== 1'b0 || err_unexp_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL unexp_vals: got ival=%b dval=%b err=%b, expected 0 0 0",
               imemresp_val, dmemresp_val, err_unexp_resp);
    end
    c_rv = 0;
    for (int k = 0; k < 3; k++) begin
      drive_cycle();
      n_checks++;
      if (err_unexp_resp !== 1'b1) begin
        n_fail++;
        $display("FAIL unexp_sticky%0d: got err=%b expected 1", k, err_unexp_resp);
      end
    end
    apply_reset();
    drive_cycle();
    n_checks++;
    if (err_unexp_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL unexp_clear: got err=%b expected 0", err_unexp_resp);
    end
  endtask

  task automatic test_reset_midop();
    idle_inputs();
    c_dv = 1; c_iv = 1; c_mr = 1;
    for (int k = 0; k < 3; k++) begin
      c_im = rand_req(); c_dm = rand_req();
      drive_cycle();
    end
    apply_reset();
    c_iv = 1; c_dv = 1; c_mr = 1; c_im = rand_req(); c_dm = rand_req();
    drive_cycle();
    n_checks++;
    if (imemreq_rdy !== 1'b1 || dmemreq_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_first_grant: got irdy=%b drdy=%b, expected 1 0",
               imemreq_rdy, dmemreq_rdy);
    end
    drain();
    c_rv = 1; c_rm = rand_resp();
    drive_cycle();
    c_rv = 0;
    drive_cycle();
    n_checks++;
    if (err_unexp_resp !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_stale_resp: got err=%b expected 1", err_unexp_resp);
    end
    apply_reset();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int k = 0; k < 400; k++) begin
      // Requesters hold val until their request has fired.
      if (!(c_iv && !exp_irdy)) begin
        c_iv = ($urandom_range(0, 1) == 1);
        c_im = rand_req();
      end
      if (!(c_dv && !exp_drdy)) begin
        c_dv = ($urandom_range(0, 1) == 1);
        c_dm = rand_req();
      end
      c_mr = ($urandom_range(0, 3) != 0);
      c_rv = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
      c_rm = rand_resp();
      drive_cycle();
      if (sel_def) begin
        n_checks++;
        if (imemreq_rdy !== exp_irdy || dmemreq_rdy !== exp_drdy) begin
          n_fail++;
          $display("FAIL rand_rdy@%0d: got irdy=%b drdy=%b, expected %b %b",
                   k, imemreq_rdy, dmemreq_rdy, exp_irdy, exp_drdy);
        end
      end
      n_checks++;
      if (memreq_val !== exp_mval || (exp_mval && memreq_msg !== exp_mmsg)) begin
        n_fail++;
        $display("FAIL rand_req@%0d: got val=%b msg=%h, expected %b %h",
                 k, memreq_val, memreq_msg, exp_mval, exp_mmsg);
      end
      n_checks++;
      if (imemresp_val !== exp_ival || dmemresp_val !== exp_dval ||
          imemresp_msg !== c_rm || dmemresp_msg !== c_rm) begin
        n_fail++;
        $display("FAIL rand_resp@%0d: got ival=%b dval=%b, expected %b %b",
                 k, imemresp_val, dmemresp_val, exp_ival, exp_dval);
      end
      n_checks++;
      if (err_unexp_resp !== exp_err) begin
        n_fail++;
        $display("FAIL rand_err@%0d: got %b expected %b", k, err_unexp_resp, exp_err);
      end
    end
    drain();
  endtask

  initial begin
    reset = 1; imemreq_val = 0; dmemreq_val = 0; memreq_rdy = 0; memresp_val = 0;
    imemreq_msg = '0; dmemreq_msg = '0; memresp_msg = '0;
    m_last = 1'b1; m_lock = -1; m_err = 1'b0;
    exp_irdy = 0; exp_drdy = 0;
    test_reset();
    test_single_imem();
    test_alternate();
    test_lock();
    test_full();
    test_unexpected();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
